id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 5-stage RISC-V core, with load-use hazard detection and branch-flush bubble insertion built in.
- Captures decoded ID-stage fields each cycle and presents them to EX, including id_ex_rs1/id_ex_rs2 for the EX forwarding unit.
- Zeroes rs1/rs2 fields for instructions that do not read them, so the forwarding unit never forwards on unused operands (lui/auipc/jal rs1; I-type/load/lui/jal rs2).

Parameters:
- XLEN, 32, data/PC width.
- CTRL_W, 8, control bundle width. bit0 reg_wb, bit1 mem_read, bit2 mem_write, others are opaque pass-through.

Ports:
- clk  in  1  core clock, rising edge
- rstn  in  1  asynchronous active-low reset
- id_valid  in  1  IF/ID holds a real instruction
- id_pc  in  XLEN  instruction PC
- id_opcode  in  7  instr[6:0]
- id_rs1, id_rs2, id_rd  in  5  register indices
- id_rd1, id_rd2  in  XLEN  register file read data
- id_imm  in  XLEN  sign-extended immediate
- id_ctrl  in  CTRL_W  decoded control bundle
- ex_flush  in  1  taken branch/jump resolved in EX
- hold  in  1  global freeze (memory wait)
- load_use_stall  out  1  combinational; freeze PC and IF/ID this cycle
- id_ex_valid  out  1  EX slot holds a real instruction
- id_ex_pc, id_ex_rd1, id_ex_rd2, id_ex_imm  out  XLEN  registered copies
- id_ex_rs1, id_ex_rs2, id_ex_rd  out  5  registered indices, masked as described below
- id_ex_opcode  out  7  registered opcode
- id_ex_ctrl  out  CTRL_W  registered control; all-zero on bubble

Behaviour:
- Reset (rstn=0, async): all id_ex_* outputs are 0, so the slot is a bubble. load_use_stall follows its equation, which evaluates to 0 because id_ex_valid=0.
- Operand-use decode on id_opcode:
  - uses_rs1 = 0 for 0110111 (lui), 0010111 (auipc), 1101111 (jal); 1 otherwise.
  - uses_rs2 = 1 only for 0110011 (R), 0100011 (S), 1100011 (B).
- Hazard:
  - hz = id_valid & id_ex_valid & id_ex_ctrl[1] & (id_ex_rd != 0) & ((uses_rs1 & id_rs1 == id_ex_rd) | (uses_rs2 & id_rs2 == id_ex_rd)).
  - load_use_stall = hz & ~ex_flush.
- Register update at posedge, in priority order:
  1. ex_flush=1: load a bubble (every field 0). Flush wins over hold and hz.
  2. hold=1: all registers keep their values.
  3. hz=1: load a bubble. IF/ID holds the load's consumer, which enters EX next cycle, one cycle after the load, for MEM/WB forwarding.
  4. Otherwise, normal load:
     - id_ex_valid = id_valid.
     - id_ex_ctrl = id_valid ? id_ctrl : 0.
     - id_ex_rs1 = uses_rs1 ? id_rs1 : 0.
     - id_ex_rs2 = uses_rs2 ? id_rs2 : 0.
     - id_ex_rd = id_valid ? id_rd : 0.
     - Data fields are copied unconditionally.
- Latency: one cycle ID to EX. A load-use pair costs exactly one bubble; back-to-back dependent loads cost one bubble each.
- x0 destination never triggers a stall. id_ex_rd=0 is harmless to forwarding.
- Reset asserted mid-stall clears the slot immediately. load_use_stall drops in the same cycle because id_ex_valid becomes 0.

Optional Feature:
- Macro ID_EX_PERF_CNT_EN.
- Defined:
  - Adds outputs bubble_cnt [31:0] and flush_cnt [31:0].
  - Both reset to 0 async.
  - bubble_cnt increments on each posedge where case 3 applies.
  - flush_cnt increments on each posedge where case 1 applies.
  - Neither counts while hold=1 without flush.
  - Both wrap at 2^32-1 → 0.
- Undefined: ports and counters are absent, and behaviour is otherwise identical.

Test Plan:
- Reset: rstn=0 mid-run with valid data in the slot → id_ex_valid=0, id_ex_ctrl=0, id_ex_rd=0 immediately, without waiting for a clock edge.
- Load-use: lw x5 in EX (ctrl[1]=1, rd=5), ID holds add x6,x5,x7 → load_use_stall=1. Next cycle id_ex_valid=0 and stall=0. Following cycle id_ex_rs1=5, id_ex_rs2=7, valid=1.
- No false stall:
  - lw x5 in EX, ID holds addi x6,x0,5 with rs2 field=5 → stall=0, and id_ex_rs2 registers as 0.
  - lui x9 with rs1 field=5 → stall=0.
- x0 load: lw x0 in EX, ID add x1,x0,x0 → stall=0.
- Flush priority: hz=1, ex_flush=1, hold=1 together → load_use_stall=0, next id_ex_valid=0, flush_cnt+1 under ID_EX_PERF_CNT_EN.
- Hold: hold=1 for 3 cycles with changing ID inputs → id_ex_* unchanged and bubble_cnt unchanged. Release → next ID instruction loaded.

Source files
------------

// File: rtl/id_ex_stage.sv
// ============================================================================
// id_ex_stage -- ID/EX pipeline register for the 5-stage RISC-V core
//
// Registers the decoded ID-stage fields for EX. It also detects load-use
// hazards and inserts bubbles for them and for branch/jump flushes.
//
// Optional build macro: ID_EX_PERF_CNT_EN
//   When defined, the outputs bubble_cnt and flush_cnt are added. They count
//   load-use bubbles and flushes.
//
// Ports:
//   clk             core clock, rising edge
//   rstn            asynchronous active-low reset
//   id_valid        IF/ID holds a real instruction
//   id_pc           instruction PC
//   id_opcode       instr[6:0]
//   id_rs1/rs2/rd   register indices from decode
//   id_rd1/rd2      register file read data
//   id_imm          sign-extended immediate
//   id_ctrl         control bundle (bit0 reg_wb, bit1 mem_read, bit2 mem_write)
//   ex_flush        taken branch/jump resolved in EX
//   hold            global freeze (memory wait)
//   load_use_stall  combinational; freeze PC and IF/ID this cycle
//   id_ex_*         registered copies presented to EX
//   bubble_cnt      (optional) load-use bubbles inserted, wraps
//   flush_cnt       (optional) flush bubbles inserted, wraps
// ============================================================================
module id_ex_stage #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [6:0]        id_opcode,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rd,
    input  logic [XLEN-1:0]   id_rd1,
    input  logic [XLEN-1:0]   id_rd2,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              ex_flush,
    input  logic              hold,
    output logic              load_use_stall,
    output logic              id_ex_valid,
    output logic [XLEN-1:0]   id_ex_pc,
    output logic [XLEN-1:0]   id_ex_rd1,
    output logic [XLEN-1:0]   id_ex_rd2,
    output logic [XLEN-1:0]   id_ex_imm,
    output logic [4:0]        id_ex_rs1,
    output logic [4:0]        id_ex_rs2,
    output logic [4:0]        id_ex_rd,
    output logic [6:0]        id_ex_opcode,
    output logic [CTRL_W-1:0] id_ex_ctrl
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [31:0]       bubble_cnt,
    output logic [31:0]       flush_cnt
`endif
);

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;

    // ------------------------------------------------------------------
    // Pipeline state
    // ------------------------------------------------------------------
    logic              valid_reg,  valid_next;
    logic [XLEN-1:0]   pc_reg,     pc_next;
    logic [XLEN-1:0]   rd1_reg,    rd1_next;
    logic [XLEN-1:0]   rd2_reg,    rd2_next;
    logic [XLEN-1:0]   imm_reg,    imm_next;
    logic [4:0]        rs1_reg,    rs1_next;
    logic [4:0]        rs2_reg,    rs2_next;
    logic [4:0]        rd_reg,     rd_next;
    logic [6:0]        opcode_reg, opcode_next;
    logic [CTRL_W-1:0] ctrl_reg,   ctrl_next;

    // ------------------------------------------------------------------
    // Operand-use decode. Unused source fields hold immediate bits, so
    // they must not be allowed to match a destination.
    // ------------------------------------------------------------------
    logic uses_rs1;
    logic uses_rs2;
    logic hz;

    always_comb begin
        uses_rs1 = !((id_opcode == OP_LUI) || (id_opcode == OP_AUIPC) ||
                     (id_opcode == OP_JAL));
        uses_rs2 = (id_opcode == OP_R) || (id_opcode == OP_S) ||
                   (id_opcode == OP_B);
    end

    // A load sits in EX and the instruction in ID needs its result. x0 as
    // destination never creates a dependency.
    assign hz = id_valid & valid_reg & ctrl_reg[1] & (rd_reg != 5'd0) &
                ((uses_rs1 & (id_rs1 == rd_reg)) |
                 (uses_rs2 & (id_rs2 == rd_reg)));

    // A flush kills the consumer in ID anyway, so no stall is needed then.
    // Hold does not mask the stall; the front end is frozen either way.
    assign load_use_stall = hz & ~ex_flush;

    // ------------------------------------------------------------------
    // Next-state selection: flush > hold > hazard bubble > normal load
    // ------------------------------------------------------------------
    always_comb begin
        valid_next  = valid_reg;
        pc_next     = pc_reg;
        rd1_next    = rd1_reg;
        rd2_next    = rd2_reg;
        imm_next    = imm_reg;
        rs1_next    = rs1_reg;
        rs2_next    = rs2_reg;
        rd_next     = rd_reg;
        opcode_next = opcode_reg;
        ctrl_next   = ctrl_reg;

        if (ex_flush || (!hold && hz)) begin
            valid_next  = 1'b0;
            pc_next     = '0;
            rd1_next    = '0;
            rd2_next    = '0;
            imm_next    = '0;
            rs1_next    = '0;
            rs2_next    = '0;
            rd_next     = '0;
            opcode_next = '0;
            ctrl_next   = '0;
        end else if (!hold) begin
            valid_next  = id_valid;
            pc_next     = id_pc;
            rd1_next    = id_rd1;
            rd2_next    = id_rd2;
            imm_next    = id_imm;
            rs1_next    = uses_rs1 ? id_rs1 : 5'd0;
            rs2_next    = uses_rs2 ? id_rs2 : 5'd0;
            rd_next     = id_valid ? id_rd : 5'd0;
            opcode_next = id_opcode;
            ctrl_next   = id_valid ? id_ctrl : '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_reg  <= 1'b0;
            pc_reg     <= '0;
            rd1_reg    <= '0;
            rd2_reg    <= '0;
            imm_reg    <= '0;
            rs1_reg    <= '0;
            rs2_reg    <= '0;
            rd_reg     <= '0;
            opcode_reg <= '0;
            ctrl_reg   <= '0;
        end else begin
            valid_reg  <= valid_next;
            pc_reg     <= pc_next;
            rd1_reg    <= rd1_next;
            rd2_reg    <= rd2_next;
            imm_reg    <= imm_next;
            rs1_reg    <= rs1_next;
            rs2_reg    <= rs2_next;
            rd_reg     <= rd_next;
            opcode_reg <= opcode_next;
            ctrl_reg   <= ctrl_next;
        end
    end

    assign id_ex_valid  = valid_reg;
    assign id_ex_pc     = pc_reg;
    assign id_ex_rd1    = rd1_reg;
    assign id_ex_rd2    = rd2_reg;
    assign id_ex_imm    = imm_reg;
    assign id_ex_rs1    = rs1_reg;
    assign id_ex_rs2    = rs2_reg;
    assign id_ex_rd     = rd_reg;
    assign id_ex_opcode = opcode_reg;
    assign id_ex_ctrl   = ctrl_reg;

`ifdef ID_EX_PERF_CNT_EN
    // ------------------------------------------------------------------
    // Performance counters; free-running, wrap naturally
    // ------------------------------------------------------------------
    logic [31:0] bubble_cnt_reg;
    logic [31:0] flush_cnt_reg;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bubble_cnt_reg <= '0;
            flush_cnt_reg  <= '0;
        end else begin
            if (ex_flush)
                flush_cnt_reg <= flush_cnt_reg + 32'd1;
            else if (!hold && hz)
                bubble_cnt_reg <= bubble_cnt_reg + 32'd1;
        end
    end

    assign bubble_cnt = bubble_cnt_reg;
    assign flush_cnt  = flush_cnt_reg;
`endif

endmodule
